// File: rtl/ws2812_pkg.sv
// Shared types, timing defaults and cycle conversion for the WS2812 driver.
package ws2812_pkg;

   typedef enum logic [1:0] {IDLE, SEND, LATCH} state_e;

   localparam int DEF_CLOCK_FREQ_HZ = 20_000_000;
   localparam int DEF_T0H_NS        = 400;
   localparam int DEF_T1H_NS        = 800;
   localparam int DEF_PERIOD_NS     = 1250;
   localparam int DEF_RESET_US      = 300;

   // Floor of freq*ns/1e9, kept in 64 bits so long reset times cannot overflow.
   function automatic longint ns_to_cycles(input longint freq, input longint ns);
      return (freq * ns) / longint'(1_000_000_000);
   endfunction

endpackage

// File: rtl/ws2812_stream_fifo.sv
// Synchronous FIFO with first-word fall-through read and a registered ready.
module sync_fifo #(
   parameter int WIDTH = 25,
   parameter int DEPTH = 8
) (
   input  logic                     clk20,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     empty,
   output logic                     ready,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             ready_q, ready_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
      // Ready looks at the next occupancy so a push into the last slot closes it.
      ready_d  = (count_d != CW'(DEPTH));
   end

   always_ff @(posedge clk20) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ready_q  <= ready_d;
      end
   end

   always_ff @(posedge clk20) begin
      if (push) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign empty = (count_q == '0);
   assign ready = ready_q;
   assign count = count_q;

endmodule

// File: rtl/ws2812_stream.sv
// Buffered WS2812 serializer: FIFO in front of a bit-timing FSM with
// latch/reset generation and a sticky underrun flag.
module ws2812_stream
   import ws2812_pkg::*;
#(
   parameter int CLOCK_FREQ_HZ = DEF_CLOCK_FREQ_HZ,
   parameter int BITS          = 24,
   parameter int FIFO_DEPTH    = 8,
   parameter int T0H_NS        = DEF_T0H_NS,
   parameter int T1H_NS        = DEF_T1H_NS,
   parameter int PERIOD_NS     = DEF_PERIOD_NS,
   parameter int RESET_US      = DEF_RESET_US,
   parameter bit INVERT        = 1'b0
) (
   input  logic                            clk20,
   input  logic                            reset,
   input  logic [BITS-1:0]                 data_in,
   input  logic                            latch,
   input  logic                            valid,
   output logic                            ready,
   output logic                            led,
   output logic [$clog2(FIFO_DEPTH):0]     level,
   output logic                            busy,
   output logic                            underrun
);

   localparam longint FREQ  = longint'(CLOCK_FREQ_HZ);
   localparam int CYC_PER   = int'(ns_to_cycles(FREQ, longint'(PERIOD_NS)));
   localparam int CYC_T0H   = int'(ns_to_cycles(FREQ, longint'(T0H_NS)));
   localparam int CYC_T1H   = int'(ns_to_cycles(FREQ, longint'(T1H_NS)));
   localparam int CYC_RES   = int'(ns_to_cycles(FREQ, longint'(RESET_US) * 1000));
   localparam int CNT_W     = $clog2(CYC_RES + 1);
   localparam int IDX_W     = $clog2(BITS);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [BITS-1:0]   sh_q, sh_d;
   logic              flag_q, flag_d;
   logic              arm_q, arm_d;
   logic              urun_q, urun_d;
   logic              led_q;

   logic              push, pop, fifo_empty, lvl;
   logic [BITS:0]     fifo_rdata;
   logic [CNT_W-1:0]  th;

   assign push = valid && ready;

   sync_fifo #(
      .WIDTH (BITS + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk20 (clk20),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata ({latch, data_in}),
      .rdata (fifo_rdata),
      .empty (fifo_empty),
      .ready (ready),
      .count (level)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      sh_d    = sh_q;
      flag_d  = flag_q;
      arm_d   = arm_q;
      urun_d  = urun_q;
      pop     = 1'b0;
      th      = sh_q[BITS-1] ? CNT_W'(CYC_T1H) : CNT_W'(CYC_T0H);
      lvl     = (state_q == SEND) && (cnt_q < th);
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               sh_d    = fifo_rdata[BITS-1:0];
               flag_d  = fifo_rdata[BITS];
               idx_d   = IDX_W'(BITS - 1);
               cnt_d   = '0;
               arm_d   = 1'b0;
               state_d = SEND;
            end else if (arm_q) begin
               if (cnt_q == CNT_W'(CYC_RES - 1)) begin
                  urun_d = 1'b1;
                  arm_d  = 1'b0;
                  cnt_d  = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         SEND: begin
            if (cnt_q == CNT_W'(CYC_PER - 1)) begin
               cnt_d = '0;
               if (idx_q != '0) begin
                  idx_d = idx_q - 1'b1;
                  sh_d  = sh_q << 1;
               end else if (flag_q) begin
                  state_d = LATCH;
               end else if (!fifo_empty) begin
                  // Back-to-back pixel: next MSB starts with no idle cycle.
                  pop    = 1'b1;
                  sh_d   = fifo_rdata[BITS-1:0];
                  flag_d = fifo_rdata[BITS];
                  idx_d  = IDX_W'(BITS - 1);
               end else begin
                  state_d = IDLE;
                  arm_d   = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         LATCH: begin
            if (cnt_q == CNT_W'(CYC_RES - 1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk20) begin
      if (reset) begin
         state_q <= LATCH;
         cnt_q   <= '0;
         idx_q   <= '0;
         sh_q    <= '0;
         flag_q  <= 1'b0;
         arm_q   <= 1'b0;
         urun_q  <= 1'b0;
         led_q   <= INVERT;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         sh_q    <= sh_d;
         flag_q  <= flag_d;
         arm_q   <= arm_d;
         urun_q  <= urun_d;
         led_q   <= lvl ^ INVERT;
      end
   end

   assign led      = led_q;
   assign busy     = (state_q != IDLE) || !fifo_empty;
   assign underrun = urun_q;

endmodule

// File: tb/tb_ws2812_stream.sv
// Scoreboard bench: 24-bit normal and 32-bit inverted instances side by side.
module tb_ws2812_stream;

   logic clk20 = 1'b0;
   logic reset = 1'b1;
   always #25 clk20 = ~clk20;

   logic [23:0] din0 = '0;
   logic        lat0 = 1'b0, val0 = 1'b0;
   logic        rdy0, led0, busy0, ur0;
   logic [3:0]  lvl0;

   logic [31:0] din1 = '0;
   logic        lat1 = 1'b0, val1 = 1'b0;
   logic        rdy1, led1, busy1, ur1;
   logic [3:0]  lvl1;

   ws2812_stream u_dut0 (
      .clk20(clk20), .reset(reset), .data_in(din0), .latch(lat0),
      .valid(val0), .ready(rdy0), .led(led0), .level(lvl0),
      .busy(busy0), .underrun(ur0)
   );

   ws2812_stream #(.BITS(32), .INVERT(1'b1)) u_dut1 (
      .clk20(clk20), .reset(reset), .data_in(din1), .latch(lat1),
      .valid(val1), .ready(rdy1), .led(led1), .level(lvl1),
      .busy(busy1), .underrun(ur1)
   );

   int cyc = 0;
   always @(posedge clk20) cyc <= cyc + 1;

   int n_run = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk20);
      #1;
   endtask

   typedef struct {
      int hw;
      bit contig;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   bit   mon_off = 1'b1;
   bit   prev[2];
   int   hcnt[2];
   int   lrise[2];

   task automatic mon(input int d, input logic l);
      exp_t e;
      bit   have;
      if (mon_off) begin
         prev[d] = l;
         hcnt[d] = 0;
         return;
      end
      have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (have) e = (d == 0) ? q0[0] : q1[0];
      if (l && !prev[d]) begin
         check($sformatf("exp_pending%0d", d), have, 1);
         if (have && e.contig)
            check($sformatf("period%0d", d), cyc - lrise[d], 25);
         lrise[d] = cyc;
         hcnt[d]  = 1;
      end else if (l) begin
         hcnt[d]++;
      end else if (prev[d] && have) begin
         check($sformatf("high_w%0d", d), hcnt[d], e.hw);
         if (d == 0) void'(q0.pop_front());
         else        void'(q1.pop_front());
      end
      prev[d] = l;
   endtask

   always @(negedge clk20) begin
      mon(0, led0);
      mon(1, ~led1);
   end

   task automatic exp_px(input int d, input logic [31:0] px, input int bits,
                         input bit c0);
      exp_t e;
      for (int i = bits - 1; i >= 0; i--) begin
         e.hw     = px[i] ? 16 : 8;
         e.contig = (i == bits - 1) ? c0 : 1'b1;
         if (d == 0) q0.push_back(e);
         else        q1.push_back(e);
      end
   endtask

   task automatic push0(input logic [23:0] px, input bit lt, input bit c0);
      int n = 0;
      din0 = px; lat0 = lt; val0 = 1'b1;
      while (!rdy0 && n < 10000) begin tick(); n++; end
      check("push0_wait", n < 10000, 1);
      exp_px(0, {8'h00, px}, 24, c0);
      tick();
      val0 = 1'b0;
   endtask

   task automatic push1(input logic [31:0] px, input bit lt, input bit c0);
      int n = 0;
      din1 = px; lat1 = lt; val1 = 1'b1;
      while (!rdy1 && n < 10000) begin tick(); n++; end
      check("push1_wait", n < 10000, 1);
      exp_px(1, px, 32, c0);
      tick();
      val1 = 1'b0;
   endtask

   task automatic wait_rise0(input int r, input string tag);
      int n = 0;
      while (!led0 && n < 8000) begin tick(); n++; end
      check(tag, cyc - r, 6002);
   endtask

   initial begin
      #(50 * 90000);
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int r;
      reset = 1'b1;
      tick();
      tick();
      r = cyc;
      check("rst_led0", led0, 0);
      check("rst_led1", led1, 1);
      check("rst_ready", rdy0, 0);
      check("rst_level", lvl0, 0);
      check("rst_busy", busy0, 1);
      check("rst_busy1", busy1, 1);
      check("rst_urun", ur0, 0);
      reset = 1'b0;
      mon_off = 1'b0;
      tick();
      check("ready_up", rdy0, 1);

      // Fill the FIFO during the post-reset latch, then stream it out.
      for (int k = 0; k < 8; k++)
         push0(24'($urandom), k == 7, k != 0);
      check("burst_level", lvl0, 8);
      check("burst_ready", rdy0, 0);
      wait_rise0(r, "latch_len");
      for (int k = 0; k < 8; k++) begin
         check($sformatf("level_k%0d", k), lvl0, 7 - k);
         repeat (600) tick();
      end
      repeat (5989) tick();
      check("burst_busy_latch", busy0, 1);
      repeat (16) tick();
      check("burst_busy_done", busy0, 0);

      push0(24'hA50F00, 1'b1, 1'b0);
      tick();
      check("lat_edge1", led0, 0);
      tick();
      check("lat_edge2", led0, 1);
      repeat (6589) tick();
      check("single_busy_latch", busy0, 1);
      repeat (16) tick();
      check("single_busy_done", busy0, 0);

      push0(24'($urandom), 1'b0, 1'b0);
      repeat (6591) tick();
      check("gap5990_urun", ur0, 0);
      push0(24'($urandom), 1'b0, 1'b0);
      check("gap5990_urun_after", ur0, 0);
      repeat (6601) tick();
      check("gap6001_urun", ur0, 1);
      push0(24'($urandom), 1'b1, 1'b0);
      repeat (6610) tick();
      check("urun_sticky", ur0, 1);

      push1(32'h8000_0001, 1'b1, 1'b0);
      tick();
      check("inv_edge1", led1, 1);
      tick();
      check("inv_edge2", led1, 0);
      repeat (6789) tick();
      check("b32_busy_latch", busy1, 1);
      repeat (16) tick();
      check("b32_busy_done", busy1, 0);

      // Abort a pixel 300 cycles in, with a second pixel still queued.
      push0(24'($urandom), 1'b1, 1'b0);
      push0(24'($urandom), 1'b1, 1'b1);
      repeat (300) tick();
      check("pre_rst_level", lvl0, 1);
      mon_off = 1'b1;
      q0.delete();
      q1.delete();
      reset = 1'b1;
      tick();
      r = cyc;
      check("abort_led", led0, 0);
      check("abort_level", lvl0, 0);
      check("abort_ready", rdy0, 0);
      check("abort_urun", ur0, 0);
      reset = 1'b0;
      tick();
      check("abort_ready_up", rdy0, 1);
      mon_off = 1'b0;
      push0(24'($urandom), 1'b1, 1'b0);
      wait_rise0(r, "abort_latch_len");
      repeat (620) tick();
      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
